vdp_super_vram_sched: RTL and testbench

Time-slot scheduler for the single 32-bit VRAM port while the super-resolution display path is enabled. It gives the super-res pixel fetch its fixed 4-cycle slot and inserts the per-line refresh. Remaining slots are shared between the CPU port and the command-engine port using round-robin arbitration. It sits between the super-res display datapath, the CPU/command requesters and the VRAM controller, and is the only driver of the VRAM address/write bus in super mode.

---
 rtl/vdp_super_sched_pkg.sv | 32 +++
 rtl/vdp_super_rr_arb.sv | 28 ++
 rtl/vdp_super_vram_sched.sv | 173 +++++++++++++++++
 tb/tb_vdp_super_vram_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_super_sched_pkg.sv
// Shared types and defaults for the super-resolution VRAM slot scheduler.
package vdp_super_sched_pkg;

  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_REFRESH_AT_X = 723;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_CMD} owner_t;
  typedef enum logic [1:0] {IDLE, PENDING, INFLIGHT} port_state_t;

  typedef struct packed {
    owner_t     owner;
    logic [1:0] lane;
    logic       wr;
  } tag_t;

  localparam tag_t TAG_NONE = '{owner: OWN_NONE, lane: 2'd0, wr: 1'b0};

  // Requester life cycle: wait for a slot, then stay busy until the ack retires the access.
  function automatic port_state_t port_next(input port_state_t s, input logic req,
                                            input logic gnt, input logic ack);
    port_state_t n;
    n = s;
    case (s)
      IDLE:     if (req) n = PENDING;
      PENDING:  if (gnt) n = INFLIGHT; else if (!req) n = IDLE;
      INFLIGHT: if (ack) n = IDLE;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vdp_super_rr_arb.sv
// Two-way round-robin picker; bit 0 is the CPU, bit 1 the command engine.
module vdp_super_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic prio_q, prio_d;  // 0: CPU favoured on a tie

  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (grant_en) begin
      if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else              grant = req;
    end
    if (grant[0])      prio_d = 1'b1;
    else if (grant[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/vdp_super_vram_sched.sv
// VRAM slot scheduler for super-res mode: display slot, refresh, requester slots.
// Define VDP_SUPER_CMD_PORT_EN to add the command-engine port and round-robin sharing.
module vdp_super_vram_sched
  import vdp_super_sched_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int REFRESH_AT_X = DEF_REFRESH_AT_X
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_super,
  input  logic [10:0] cx,
  input  logic        super_res_drawing,
  input  logic [16:0] super_res_vram_addr,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
`ifdef VDP_SUPER_CMD_PORT_EN
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        cmd_ack,
  output logic [7:0]  cmd_rdata,
`endif
  output logic [16:0] vram_addr,
  output logic        vram_wr,
  output logic [3:0]  vram_be,
  output logic [31:0] vram_wdata,
  output logic        vram_refresh,
  input  logic [31:0] vram_rdata
);

  // Decisions are made one cycle ahead so the bus is registered during the slot itself.
  logic [10:0] cx_next;
  logic        refresh_next, disp_next, req_slot_next;

  always_comb begin
    cx_next       = cx + 11'd1;
    refresh_next  = (cx_next == 11'(REFRESH_AT_X));
    disp_next     = vdp_super && super_res_drawing && (cx[1:0] == 2'd0);
    req_slot_next = !cx[0] && !disp_next && !refresh_next;
  end

  port_state_t cpu_st_q, cpu_st_d;
  logic        cpu_elig, gnt_cpu, gnt_any;
  tag_t        exit_tag;
  logic [7:0]  rd_byte;

  assign cpu_elig = (cpu_st_q == PENDING) && cpu_req;

`ifdef VDP_SUPER_CMD_PORT_EN
  port_state_t cmd_st_q, cmd_st_d;
  logic        cmd_elig, gnt_cmd;
  logic [1:0]  grant;

  assign cmd_elig = (cmd_st_q == PENDING) && cmd_req;

  vdp_super_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({cmd_elig, cpu_elig}),
    .grant_en (req_slot_next),
    .grant    (grant)
  );

  assign gnt_cpu = grant[0];
  assign gnt_cmd = grant[1];
  assign gnt_any = gnt_cpu || gnt_cmd;
`else
  assign gnt_cpu = req_slot_next && cpu_elig;
  assign gnt_any = gnt_cpu;
`endif

  owner_t      sel_owner;
  logic        sel_wr;
  logic [18:0] sel_addr;
  logic [7:0]  sel_wdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_owner = OWN_CPU;
    sel_wr    = cpu_wr;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
`ifdef VDP_SUPER_CMD_PORT_EN
    if (gnt_cmd) begin
      sel_owner = OWN_CMD;
      sel_wr    = cmd_wr;
      sel_addr  = cmd_addr;
      sel_wdata = cmd_wdata;
    end
`endif
  end

  logic [16:0] addr_q, addr_d;
  logic        wr_q, wr_d, refresh_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  tag_t        iss_q, iss_d;
  tag_t        pipe_q [READ_LATENCY];
  tag_t        pipe_d [READ_LATENCY];

  always_comb begin
    addr_d  = '0;
    wr_d    = 1'b0;
    be_d    = '0;
    wdata_d = '0;
    iss_d   = TAG_NONE;
    if (disp_next) begin
      addr_d = super_res_vram_addr;
    end else if (gnt_any) begin
      addr_d  = sel_addr[18:2];
      wr_d    = sel_wr;
      be_d    = sel_wr ? (4'b0001 << sel_addr[1:0]) : 4'hF;
      wdata_d = sel_wr ? {4{sel_wdata}} : 32'h0;
      iss_d   = '{owner: sel_owner, lane: sel_addr[1:0], wr: sel_wr};
    end
    pipe_d[0] = iss_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign exit_tag = pipe_q[READ_LATENCY-1];
  assign rd_byte  = vram_rdata[{exit_tag.lane, 3'b000} +: 8];
  assign cpu_ack  = (exit_tag.owner == OWN_CPU);
  assign cpu_rdata = (cpu_ack && !exit_tag.wr) ? rd_byte : 8'h00;
  assign cpu_st_d = port_next(cpu_st_q, cpu_req, gnt_cpu, cpu_ack);
`ifdef VDP_SUPER_CMD_PORT_EN
  assign cmd_ack   = (exit_tag.owner == OWN_CMD);
  assign cmd_rdata = (cmd_ack && !exit_tag.wr) ? rd_byte : 8'h00;
  assign cmd_st_d  = port_next(cmd_st_q, cmd_req, gnt_cmd, cmd_ack);
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      refresh_q <= 1'b0;
      iss_q     <= TAG_NONE;
      cpu_st_q  <= IDLE;
`ifdef VDP_SUPER_CMD_PORT_EN
      cmd_st_q  <= IDLE;
`endif
      // NOTE: the tag pipeline is reset, unlike a data RAM: a stale tag would fire a false ack.
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= TAG_NONE;
    end else begin
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      refresh_q <= refresh_next;
      iss_q     <= iss_d;
      cpu_st_q  <= cpu_st_d;
`ifdef VDP_SUPER_CMD_PORT_EN
      cmd_st_q  <= cmd_st_d;
`endif
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign vram_addr    = addr_q;
  assign vram_wr      = wr_q;
  assign vram_be      = be_q;
  assign vram_wdata   = wdata_q;
  assign vram_refresh = refresh_q;

endmodule

// File: tb/tb_vdp_super_vram_sched.sv
// Randomized bench for vdp_super_vram_sched against a slot-table reference model.
// Builds with or without VDP_SUPER_CMD_PORT_EN.
module tb_vdp_super_vram_sched;

  localparam int RL    = 2;
  localparam int REF_X = 723;
  localparam int LINE  = 1368;
`ifdef VDP_SUPER_CMD_PORT_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vdp_super = 1'b0;
  logic [10:0] cx = '0;
  logic        super_res_drawing = 1'b0;
  logic [16:0] super_res_vram_addr = '0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
`ifdef VDP_SUPER_CMD_PORT_EN
  logic        cmd_req = 1'b0, cmd_wr = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_ack;
  logic [7:0]  cmd_rdata;
`endif
  logic [16:0] vram_addr;
  logic        vram_wr;
  logic [3:0]  vram_be;
  logic [31:0] vram_wdata;
  logic        vram_refresh;
  logic [31:0] vram_rdata = '0;

  vdp_super_vram_sched dut (
    .clk                 (clk),
    .reset               (reset),
    .vdp_super           (vdp_super),
    .cx                  (cx),
    .super_res_drawing   (super_res_drawing),
    .super_res_vram_addr (super_res_vram_addr),
    .cpu_req             (cpu_req),
    .cpu_wr              (cpu_wr),
    .cpu_addr            (cpu_addr),
    .cpu_wdata           (cpu_wdata),
    .cpu_ack             (cpu_ack),
    .cpu_rdata           (cpu_rdata),
`ifdef VDP_SUPER_CMD_PORT_EN
    .cmd_req             (cmd_req),
    .cmd_wr              (cmd_wr),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .cmd_ack             (cmd_ack),
    .cmd_rdata           (cmd_rdata),
`endif
    .vram_addr           (vram_addr),
    .vram_wr             (vram_wr),
    .vram_be             (vram_be),
    .vram_wdata          (vram_wdata),
    .vram_refresh        (vram_refresh),
    .vram_rdata          (vram_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d cx=%0d got=%h want=%h", tag, cyc, cx, obs, exp);
  endtask

  // Requester bookkeeping (index 0 = CPU, 1 = command engine).
  bit          act [2];
  bit          gnt [2];
  bit          done [2];
  int          start [2];
  bit          wr_r [2];
  logic [18:0] addr_r [2];
  logic [7:0]  wd_r [2];
  bit          want [2];
  bit          want_wr [2];
  logic [18:0] want_addr [2];
  logic [7:0]  want_wd [2];
  int          last;      // port granted most recently
  int          mode;      // 0 directed, 1 both ports always requesting, 2 random
  bit          rst_next;
  bit          fixed_rd_en;
  logic [31:0] fixed_rd;
  bit          cfg_super, cfg_draw;
  logic [16:0] cfg_daddr;

  // Expected outputs, indexed by cycle number modulo 8.
  logic [16:0] e_addr [8];
  bit          e_wr [8];
  logic [3:0]  e_be [8];
  logic [31:0] e_wd [8];
  bit          e_ref [8];
  bit          e_ack [2][8];
  int          e_lane [2][8];
  bit          e_w [2][8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      e_addr[i] = '0; e_wr[i] = 0; e_be[i] = '0; e_wd[i] = '0; e_ref[i] = 0;
      for (int p = 0; p < 2; p++) begin e_ack[p][i] = 0; e_lane[p][i] = 0; e_w[p][i] = 0; end
    end
    for (int p = 0; p < 2; p++) begin act[p] = 0; gnt[p] = 0; done[p] = 0; want[p] = 0; end
    last = 1;
  endtask

  task automatic new_req(input int p, input bit w, input logic [18:0] a, input logic [7:0] d);
    act[p] = 1; gnt[p] = 0; start[p] = cyc;
    wr_r[p] = w; addr_r[p] = a; wd_r[p] = d;
  endtask

  task automatic want_req(input int p, input bit w, input logic [18:0] a, input logic [7:0] d);
    want[p] = 1; want_wr[p] = w; want_addr[p] = a; want_wd[p] = d;
  endtask

  task automatic drive_ports();
    bit aborted;
    for (int p = 0; p < NP; p++) begin
      aborted = 0;
      if (done[p]) begin act[p] = 0; done[p] = 0; end
      if (mode == 2 && act[p] && !gnt[p] && $urandom_range(0, 15) == 0) begin
        act[p] = 0; aborted = 1;
      end
      if (!act[p] && !aborted) begin
        if (want[p]) begin
          new_req(p, want_wr[p], want_addr[p], want_wd[p]);
          want[p] = 0;
        end else if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
          new_req(p, 1'($urandom), 19'($urandom), 8'($urandom));
        end
      end
    end
    cpu_req = act[0]; cpu_wr = wr_r[0]; cpu_addr = addr_r[0]; cpu_wdata = wd_r[0];
`ifdef VDP_SUPER_CMD_PORT_EN
    cmd_req = act[1]; cmd_wr = wr_r[1]; cmd_addr = addr_r[1]; cmd_wdata = wd_r[1];
`endif
  endtask

  // Slot table: what the bus must carry in the cycle after this one, and when acks return.
  task automatic model_decide();
    int nx, k, ka, w;
    bit el [2];
    nx = (int'(cx) + 1) % LINE;
    k  = (cyc + 1) % 8;
    e_addr[k] = '0; e_wr[k] = 0; e_be[k] = '0; e_wd[k] = '0;
    e_ref[k]  = (nx == REF_X);
    if (cx[1:0] == 2'd0 && vdp_super && super_res_drawing) begin
      e_addr[k] = super_res_vram_addr;
    end else if ((cx[1:0] == 2'd0 || cx[1:0] == 2'd2) && nx != REF_X) begin
      for (int p = 0; p < 2; p++) el[p] = (p < NP) && act[p] && !gnt[p] && (start[p] < cyc);
      w = -1;
      if (el[0] && el[1]) w = (last == 0) ? 1 : 0;
      else if (el[0])     w = 0;
      else if (el[1])     w = 1;
      if (w >= 0) begin
        last = w; gnt[w] = 1;
        e_addr[k] = addr_r[w][18:2];
        e_wr[k]   = wr_r[w];
        e_be[k]   = wr_r[w] ? (4'b0001 << addr_r[w][1:0]) : 4'hF;
        e_wd[k]   = wr_r[w] ? {4{wd_r[w]}} : 32'h0;
        ka = (cyc + 1 + RL) % 8;
        e_ack[w][ka] = 1; e_lane[w][ka] = int'(addr_r[w][1:0]); e_w[w][ka] = wr_r[w];
      end
    end
  endtask

  task automatic chk_port(input int p, input logic ack_obs, input logic [7:0] rd_obs);
    int k;
    logic [31:0] exp_rd;
    k = cyc % 8;
    exp_rd = (e_ack[p][k] && !e_w[p][k]) ? ((vram_rdata >> (8 * e_lane[p][k])) & 32'hFF) : 32'h0;
    check(p == 0 ? "cpu_ack" : "cmd_ack", {31'b0, ack_obs}, {31'b0, e_ack[p][k]});
    check(p == 0 ? "cpu_rdata" : "cmd_rdata", {24'b0, rd_obs}, exp_rd);
    if (e_ack[p][k]) done[p] = 1;
    e_ack[p][k] = 0;
  endtask

  task automatic check_outputs();
    int k;
    k = cyc % 8;
    check("vram_addr", {15'b0, vram_addr}, {15'b0, e_addr[k]});
    check("vram_wr", {31'b0, vram_wr}, {31'b0, e_wr[k]});
    check("vram_be", {28'b0, vram_be}, {28'b0, e_be[k]});
    check("vram_wdata", vram_wdata, e_wd[k]);
    check("vram_refresh", {31'b0, vram_refresh}, {31'b0, e_ref[k]});
    chk_port(0, cpu_ack, cpu_rdata);
`ifdef VDP_SUPER_CMD_PORT_EN
    chk_port(1, cmd_ack, cmd_rdata);
`endif
    e_addr[k] = '0; e_wr[k] = 0; e_be[k] = '0; e_wd[k] = '0; e_ref[k] = 0;
  endtask

  // One clock: drive inputs after the edge, predict, then check on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cx = (cx == 11'(LINE - 1)) ? 11'd0 : cx + 11'd1;
    if (rst_next && !reset) begin
      reset = 1'b1;
      model_reset();
    end else if (!rst_next && reset) begin
      reset = 1'b0;
    end
    if (cx[1:0] == 2'd2) begin
      if (mode == 2) begin
        cfg_super = ($urandom_range(0, 7) != 0);
        cfg_draw  = ($urandom_range(0, 3) != 0);
        cfg_daddr = 17'($urandom);
      end
      vdp_super = cfg_super; super_res_drawing = cfg_draw; super_res_vram_addr = cfg_daddr;
    end
    vram_rdata = fixed_rd_en ? fixed_rd : $urandom;
    if (!reset) begin
      drive_ports();
      model_decide();
    end else begin
      drive_ports();
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_idle(input int p, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!act[p] && !want[p]) break;
      step();
    end
  endtask

  initial begin
    model_reset();
    mode = 0; rst_next = 1; fixed_rd_en = 0; fixed_rd = '0;
    cfg_super = 0; cfg_draw = 0; cfg_daddr = '0;
    repeat (3) step();
    rst_next = 0;

    // Display slots only.
    cfg_super = 1; cfg_draw = 1; cfg_daddr = 17'h00123;
    repeat (20) step();

    // CPU read and write inside the drawing window.
    fixed_rd_en = 1; fixed_rd = 32'hAABBCCDD;
    want_req(0, 1'b0, 19'h00006, 8'h00);
    run_until_idle(0, 40);
    want_req(0, 1'b1, 19'h00003, 8'h5A);
    run_until_idle(0, 40);
    fixed_rd_en = 0;

`ifdef VDP_SUPER_CMD_PORT_EN
    // Contention: both ports keep requesting.
    mode = 1;
    repeat (80) step();
    mode = 0;
    run_until_idle(0, 60);
    run_until_idle(1, 60);
`endif

    // Refresh slot with a CPU request pending across cx=722.
    for (int i = 0; i < LINE + 8 && cx != 11'd719; i++) step();
    want_req(0, 1'b0, 19'h4ABC5, 8'h00);
    run_until_idle(0, 40);

    // Reset one cycle after a CPU issue, then a fresh request.
    want_req(0, 1'b0, 19'h12345, 8'h00);
    for (int i = 0; i < 40 && !gnt[0]; i++) step();
    step();
    rst_next = 1;
    repeat (2) step();
    rst_next = 0;
    repeat (10) step();
    want_req(0, 1'b1, 19'h00F01, 8'hC3);
    run_until_idle(0, 40);

    // Random traffic across several lines.
    mode = 2;
    repeat (6000) step();
    mode = 0;
    run_until_idle(0, 60);
    run_until_idle(1, 60);
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
